vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

Arbitrates the single video memory port between the CRTC-paced display fetch path and CPU Wishbone accesses. Display words are prefetched into a small FIFO that the renderer drains in step with the horizontal and vertical timing. The CPU is served in the gaps between fetches. The block sits between the CRTC and sequencer on one side, and the video SRAM controller on the other.

## Interface
- `AW`, 17 — word address width
- `DW`, 16 — data width
- `DEPTH`, 4 — prefetch FIFO depth (power of two, ≥2)
- `clk` in 1 — 25 MHz clock
- `rst` in 1 — synchronous, active-high reset
- `enable_crtc` in 1 — pixel strobe; qualifies `frame_start`, `line_start`, `pix_rd`
- `frame_start` in 1 — pulse at v_count=0, h_count=0
- `line_start` in 1 — pulse at h_count=0 of every line, including the frame's first line
- `video_on_v` in 1 — vertical active region
- `start_addr` in AW — frame base word address
- `pitch` in 8 — words added to line base per line
- `line_words` in 8 — words fetched per line (0 = none)
- `pix_rd` in 1 — pop FIFO head
- `pix_dat` out DW — FIFO head
- `pix_valid` out 1 — FIFO non-empty
- `underflow` out 1 — sticky; set when `pix_rd` is asserted on an empty FIFO
- `wbs_adr_i` in AW, `wbs_dat_i` in DW, `wbs_sel_i` in 2, `wbs_we_i` in 1, `wbs_stb_i` in 1, `wbs_cyc_i` in 1 — CPU slave
- `wbs_dat_o` out DW, `wbs_ack_o` out 1
- `mem_adr_o` out AW, `mem_dat_o` out DW, `mem_sel_o` out 2, `mem_we_o` out 1, `mem_req_o` out 1 — memory master
- `mem_dat_i` in DW, `mem_ack_i` in 1 — read data is valid in the `mem_ack_i` cycle

## Operation
- States: IDLE, DISP, CPU. At most one memory transaction is outstanding.
- `level` = FIFO count + (1 if in DISP). `disp_want` = `video_on_v` & `fetched` < `line_words` & `level` < DEPTH. `disp_urgent` = `disp_want` & `level` < DEPTH/2. `cpu_req` = `wbs_cyc_i` & `wbs_stb_i`.
- IDLE priority:
  1. `disp_urgent` → DISP
  2. else `cpu_req` → CPU
  3. else `disp_want` → DISP
  4. else stay in IDLE
- DISP:
  - `mem_adr_o` = `line_base` + `fetched`; `mem_we_o` = 0; `mem_sel_o` = 2'b11.
  - On `mem_ack_i`: push `mem_dat_i` unless `drop` is set; `fetched`++; go to IDLE.
- CPU:
  - Drive `wbs_adr_i`, `wbs_dat_i`, `wbs_sel_i`, `wbs_we_i` to the memory port.
  - On `mem_ack_i`: register `mem_dat_i` into `wbs_dat_o`, pulse `wbs_ack_o` for 1 cycle, go to IDLE.
- `mem_req_o` = 1 in DISP and CPU; address and control are registered at state entry and held until ack.
- Mandatory IDLE cycle between transactions; a continuously requesting CPU cannot starve a non-urgent display.
- `frame_start` (qualified): `line_base` ← `start_addr`.
- `line_start` (qualified, not coincident with `frame_start`): `line_base` ← `line_base` + `pitch`. Addition is AW-bit and wraps modulo 2^AW.
- Any qualified `line_start`:
  - FIFO flushed; `fetched` ← 0.
  - If in DISP, set `drop`; the in-flight data is discarded at ack and `fetched` stays 0. `drop` clears at that ack.
- Simultaneous push and pop: count unchanged. Pop on empty: ignored and `underflow` set. `underflow` clears only on `rst`.
- A CPU cycle dropped mid-transaction (`cyc` deasserted) still completes on the memory side. `wbs_ack_o` is suppressed if `cyc` is low at ack.

## Timing
- Reset values:
  - state IDLE
  - `mem_req_o`, `mem_we_o`, `wbs_ack_o`, `underflow`, `drop` = 0
  - `mem_adr_o`, `mem_dat_o`, `mem_sel_o`, `wbs_dat_o` = 0
  - FIFO empty, so `pix_valid` = 0 and `pix_dat` = 0
  - `line_base` = 0, `fetched` = 0
- `rst` mid-transaction: takes effect next cycle and abandons the transaction.
- Request latency: IDLE decision at edge N, so `mem_req_o` = 1 from N+1.
- Ack to state: `mem_ack_i` at cycle M → IDLE at M+1, next request earliest at M+2.
- CPU data: `wbs_ack_o` and `wbs_dat_o` valid at M+1.
- FIFO: push at ack M → `pix_valid` at M+1. `pix_dat` is combinational from the FIFO head.
- Best case with 1-cycle memory: one display word every 3 cycles.

## Structure
- Package `vga_mem_pkg`: state encoding (IDLE = 0, DISP = 1, CPU = 2) and default widths.
- Sub-module `vga_fetch_fifo` (DEPTH × DW register FIFO with push, pop, flush, count, empty).
- Arbiter FSM, address generation and Wishbone glue stay in the top level.

## Test plan
- Reset, then `frame_start` with `start_addr` = 0x1000, `line_words` = 4, memory ack latency 1, no CPU activity → reads at 0x1000 to 0x1003, `pix_valid` after the first ack, no `underflow`.
- Second `line_start` with `pitch` = 80 → reads start at 0x1050. Repeat with `start_addr` = 0x1FFF0 and `pitch` = 0x20 → line base wraps to 0x00010.
- Continuous CPU writes with the FIFO at count 3 (not urgent) → CPU served alternately with the display. With the FIFO drained to 1 → DISP wins the next IDLE decision.
- CPU read of 0x0200 returning 0xBEEF → `wbs_ack_o` 1 cycle, `wbs_dat_o` = 0xBEEF, `mem_we_o` = 0 throughout.
- `line_start` during an outstanding DISP read → data dropped, FIFO count 0, next read at the new line base + 0.
- `pix_rd` on empty FIFO → `underflow` = 1 until `rst`. Simultaneous push and pop at count 2 → count stays 2.

Source files
------------

// File: rtl/vga_mem_pkg.sv
// Shared state encoding and default widths for the video memory arbiter.
package vga_mem_pkg;

    localparam int unsigned AW_DEF    = 17;
    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned SEL_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_fetch_fifo.sv
// Register-based prefetch FIFO holding display words ahead of the renderer.
module vga_fetch_fifo
    import vga_mem_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pops on empty are ignored; a push into a full FIFO only lands alongside a pop.
    always_comb begin
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
        head    = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares the video SRAM port between CRTC-paced display prefetch and CPU Wishbone accesses.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_crtc,
    input  logic             frame_start,
    input  logic             line_start,
    input  logic             video_on_v,
    input  logic [AW-1:0]    start_addr,
    input  logic [7:0]       pitch,
    input  logic [7:0]       line_words,
    input  logic             pix_rd,
    output logic [DW-1:0]    pix_dat,
    output logic             pix_valid,
    output logic             underflow,
    input  logic [AW-1:0]    wbs_adr_i,
    input  logic [DW-1:0]    wbs_dat_i,
    input  logic [SEL_W-1:0] wbs_sel_i,
    input  logic             wbs_we_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    output logic [DW-1:0]    wbs_dat_o,
    output logic             wbs_ack_o,
    output logic [AW-1:0]    mem_adr_o,
    output logic [DW-1:0]    mem_dat_o,
    output logic [SEL_W-1:0] mem_sel_o,
    output logic             mem_we_o,
    output logic             mem_req_o,
    input  logic [DW-1:0]    mem_dat_i,
    input  logic             mem_ack_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    arb_state_e    state;
    logic [AW-1:0] line_base;
    logic [7:0]    fetched;
    logic          drop;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          frame_q;
    logic          line_q;
    logic          pop_q;
    logic          push;
    logic [CW-1:0] level;
    logic          disp_want;
    logic          disp_urgent;
    logic          cpu_req;
    logic          go_disp;
    logic          go_cpu;

    // Arbitration terms. The ack cycle masks the CPU so a master still holding
    // stb while it sees ack is not served twice. A qualified line_start blocks
    // a display grant that would otherwise fetch from the outgoing line.
    always_comb begin
        frame_q     = enable_crtc & frame_start;
        line_q      = enable_crtc & line_start;
        pop_q       = enable_crtc & pix_rd;
        level       = fifo_count + CW'(state == ST_DISP);
        disp_want   = video_on_v && (fetched < line_words) && (level < CW'(DEPTH));
        disp_urgent = disp_want && (level < CW'(DEPTH / 2));
        cpu_req     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
        go_disp     = (state == ST_IDLE) && !line_q && (disp_urgent || (disp_want && !cpu_req));
        go_cpu      = (state == ST_IDLE) && cpu_req && !go_disp;
        push        = (state == ST_DISP) && mem_ack_i && !drop && !line_q;
        pix_valid   = !fifo_empty;
    end

    vga_fetch_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (mem_dat_i),
        .pop      (pop_q),
        .flush    (line_q),
        .head     (pix_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // Arbiter FSM; memory command is captured at state entry and held until ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_adr_o <= '0;
            mem_dat_o <= '0;
            mem_sel_o <= '0;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go_disp) begin
                        state     <= ST_DISP;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= 1'b0;
                        mem_sel_o <= '1;
                        mem_adr_o <= line_base + AW'(fetched);
                    end else if (go_cpu) begin
                        state     <= ST_CPU;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= wbs_we_i;
                        mem_sel_o <= wbs_sel_i;
                        mem_adr_o <= wbs_adr_i;
                        mem_dat_o <= wbs_dat_i;
                    end
                end
                ST_DISP: begin
                    if (mem_ack_i) begin
                        state     <= ST_IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end
                end
                ST_CPU: begin
                    if (mem_ack_i) begin
                        state     <= ST_IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        wbs_dat_o <= mem_dat_i;
                        wbs_ack_o <= wbs_cyc_i;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

    // Line addressing and the in-flight discard flag for a read overtaken by a new line.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_base <= '0;
            fetched   <= '0;
            drop      <= 1'b0;
        end else begin
            if (frame_q) begin
                line_base <= start_addr;
            end else if (line_q) begin
                line_base <= line_base + AW'(pitch);
            end

            if (line_q) begin
                fetched <= '0;
            end else if ((state == ST_DISP) && mem_ack_i && !drop) begin
                fetched <= fetched + 8'd1;
            end

            if (state == ST_DISP) begin
                if (mem_ack_i) begin
                    drop <= 1'b0;
                end else if (line_q) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (pop_q && fifo_empty) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Randomized bench for vga_mem_arbiter against a transaction-level reference model.
module tb_vga_mem_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_crtc, frame_start, line_start, video_on_v, pix_rd;
    logic [AW-1:0] start_addr;
    logic [7:0]    pitch, line_words;
    logic [DW-1:0] pix_dat;
    logic          pix_valid, underflow;
    logic [AW-1:0] wbs_adr_i;
    logic [DW-1:0] wbs_dat_i;
    logic [1:0]    wbs_sel_i;
    logic          wbs_we_i, wbs_stb_i, wbs_cyc_i;
    logic [DW-1:0] wbs_dat_o;
    logic          wbs_ack_o;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_dat_o;
    logic [1:0]    mem_sel_o;
    logic          mem_we_o, mem_req_o;
    logic [DW-1:0] mem_dat_i;
    logic          mem_ack_i;

    always #20 clk = ~clk;

    vga_mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable_crtc(enable_crtc), .frame_start(frame_start),
        .line_start(line_start), .video_on_v(video_on_v), .start_addr(start_addr),
        .pitch(pitch), .line_words(line_words), .pix_rd(pix_rd), .pix_dat(pix_dat),
        .pix_valid(pix_valid), .underflow(underflow), .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
        .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o), .mem_req_o(mem_req_o),
        .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: who owns the port, the queued words and line bookkeeping.
    int            m_owner;
    logic [DW-1:0] m_q[$];
    int            m_fetched;
    logic [AW-1:0] m_base;
    bit            m_drop, m_under, m_req, m_we, m_ack;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dato, m_wdat;
    logic [1:0]    m_sel;

    int            lat = 1;
    int            rcnt = 0;
    bit            ovr_en = 0;
    logic [DW-1:0] ovr_dat = '0;
    int            cpu_mode = 0;
    int            cpu_gap = 0;
    bit            prev_req = 0;
    logic [AW-1:0] disp_log[$];

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return DW'(a) ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit qls, qfs, pop, cpu, want, urgent, push;
        int level;
        if (rst) begin
            m_owner = 0; m_q.delete(); m_fetched = 0; m_base = '0; m_drop = 0; m_under = 0;
            m_req = 0; m_we = 0; m_ack = 0; m_adr = '0; m_dato = '0; m_wdat = '0; m_sel = '0;
            return;
        end
        qls    = enable_crtc && line_start;
        qfs    = enable_crtc && frame_start;
        pop    = enable_crtc && pix_rd;
        level  = m_q.size() + ((m_owner == 1) ? 1 : 0);
        want   = video_on_v && (m_fetched < int'(line_words)) && (level < DEPTH);
        urgent = want && (level < DEPTH / 2);
        cpu    = wbs_cyc_i && wbs_stb_i && !m_ack;
        push   = 0;
        m_ack  = 0;
        if (m_owner == 0) begin
            if (!qls && (urgent || (want && !cpu))) begin
                m_owner = 1; m_req = 1; m_we = 0; m_sel = 2'b11;
                m_adr = m_base + AW'(m_fetched);
            end else if (cpu) begin
                m_owner = 2; m_req = 1; m_we = wbs_we_i; m_sel = wbs_sel_i;
                m_adr = wbs_adr_i; m_dato = wbs_dat_i;
            end
        end else if (m_owner == 1) begin
            if (mem_ack_i) begin
                push = !m_drop && !qls;
                if (!m_drop) m_fetched++;
                m_drop = 0; m_owner = 0; m_req = 0; m_we = 0;
            end else if (qls) begin
                m_drop = 1;
            end
        end else begin
            if (mem_ack_i) begin
                m_wdat = mem_dat_i; m_ack = wbs_cyc_i; m_owner = 0; m_req = 0; m_we = 0;
            end
        end
        if (pop && m_q.size() == 0) m_under = 1;
        if (qls) begin
            m_q.delete();
            m_fetched = 0;
        end else begin
            if (pop && m_q.size() > 0) void'(m_q.pop_front());
            if (push) m_q.push_back(mem_dat_i);
        end
        if (qfs) m_base = start_addr;
        else if (qls) m_base = m_base + AW'(pitch);
    endtask

    task automatic compare();
        check("mem_req", 32'(mem_req_o), 32'(m_req));
        if (m_req) begin
            check("mem_adr", 32'(mem_adr_o), 32'(m_adr));
            check("mem_we", 32'(mem_we_o), 32'(m_we));
            check("mem_sel", 32'(mem_sel_o), 32'(m_sel));
            if (m_we) check("mem_dat", 32'(mem_dat_o), 32'(m_dato));
        end
        check("wbs_ack", 32'(wbs_ack_o), 32'(m_ack));
        check("wbs_dat", 32'(wbs_dat_o), 32'(m_wdat));
        check("pix_valid", 32'(pix_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("pix_dat", 32'(pix_dat), 32'(m_q[0]));
        check("underflow", 32'(underflow), 32'(m_under));
    endtask

    task automatic responder();
        if (mem_ack_i) begin
            mem_ack_i = 0; rcnt = 0;
        end else if (mem_req_o === 1'b1 && !rst) begin
            if (rcnt >= lat) begin
                mem_ack_i = 1; rcnt = 0;
                mem_dat_i = ovr_en ? ovr_dat : mem_f(mem_adr_o);
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
        if (!mem_ack_i) mem_dat_i = DW'($urandom);
    endtask

    task automatic cpu_drive();
        if (wbs_cyc_i && wbs_stb_i && wbs_ack_o === 1'b1) begin
            wbs_cyc_i = 0; wbs_stb_i = 0;
        end else if (wbs_cyc_i && cpu_mode == 2 && $urandom_range(0, 31) == 0) begin
            wbs_cyc_i = 0; wbs_stb_i = 0; cpu_gap = 6;
        end else if (!wbs_cyc_i && cpu_mode != 0) begin
            if (cpu_gap > 0) cpu_gap--;
            else if (cpu_mode == 1 || $urandom_range(0, 3) == 0) begin
                wbs_cyc_i = 1; wbs_stb_i = 1;
                wbs_adr_i = AW'($urandom); wbs_dat_i = DW'($urandom);
                wbs_sel_i = 2'($urandom_range(1, 3));
                wbs_we_i  = (cpu_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic tick();
        cpu_drive();
        responder();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (mem_req_o && !prev_req && !mem_we_o) disp_log.push_back(mem_adr_o);
        prev_req = mem_req_o;
    endtask

    task automatic pulse_line(input bit with_frame);
        line_start = 1; frame_start = with_frame;
        tick();
        line_start = 0; frame_start = 0;
    endtask

    task automatic log_check(input string name, input int idx, input logic [AW-1:0] exp);
        if (disp_log.size() > idx) check(name, 32'(disp_log[idx]), 32'(exp));
        else begin
            n_checks++;
            $display("FAIL %s: only %0d reads logged, expected address %h", name, disp_log.size(), exp);
        end
    endtask

    initial begin
        bit seen_we;
        bit got;
        rst = 1; enable_crtc = 1; frame_start = 0; line_start = 0; video_on_v = 0; pix_rd = 0;
        start_addr = '0; pitch = '0; line_words = '0;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 0; wbs_stb_i = 0; wbs_cyc_i = 0;
        mem_dat_i = '0; mem_ack_i = 0;
        tick(); tick();
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_adr", 32'(mem_adr_o), 32'd0);
        check("rst_mem_sel", 32'(mem_sel_o), 32'd0);
        check("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_wbs_dat", 32'(wbs_dat_o), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_dat", 32'(pix_dat), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        rst = 0;

        // First line of a frame at 0x1000, four words, 1-cycle memory.
        start_addr = 17'h01000; pitch = 8'd80; line_words = 8'd4; video_on_v = 1; lat = 1;
        disp_log.delete();
        pulse_line(1);
        repeat (20) tick();
        check("line0_reads", 32'(disp_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) log_check("line0_adr", i, 17'h01000 + 17'(i));
        check("line0_valid", 32'(pix_valid), 32'd1);
        check("line0_pixdat", 32'(pix_dat), 32'(16'h1000 ^ 16'h5A3C));
        check("line0_underflow", 32'(underflow), 32'd0);

        pix_rd = 1; repeat (4) tick(); pix_rd = 0;
        disp_log.delete();
        pulse_line(0);
        repeat (20) tick();
        log_check("line1_adr0", 0, 17'h01050);
        log_check("line1_adr3", 3, 17'h01053);

        // Line base wrap across the top of the address space.
        start_addr = 17'h1FFF0; pitch = 8'h20;
        pulse_line(1);
        repeat (20) tick();
        disp_log.delete();
        pulse_line(0);
        repeat (20) tick();
        log_check("wrap_adr0", 0, 17'h00010);

        // CPU read with a known returned value.
        video_on_v = 0;
        repeat (6) tick();
        ovr_en = 1; ovr_dat = 16'hBEEF;
        wbs_adr_i = 17'h00200; wbs_we_i = 0; wbs_sel_i = 2'b11; wbs_cyc_i = 1; wbs_stb_i = 1;
        seen_we = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (mem_we_o) seen_we = 1;
            if (wbs_ack_o) got = 1;
        end
        check("cpu_rd_ack", 32'(got), 32'd1);
        check("cpu_rd_dat", 32'(wbs_dat_o), 32'h0000BEEF);
        check("cpu_rd_we", 32'(seen_we), 32'd0);
        tick();
        check("cpu_rd_ack_pulse", 32'(wbs_ack_o), 32'd0);
        ovr_en = 0;

        // New line arriving while a display read is outstanding.
        start_addr = 17'h00800; pitch = 8'h10; line_words = 8'd4; video_on_v = 1; lat = 3;
        pulse_line(1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (mem_req_o) got = 1;
        end
        check("drop_req_seen", 32'(got), 32'd1);
        pulse_line(0);
        disp_log.delete();
        repeat (30) tick();
        log_check("drop_next_adr", 0, 17'h00810);

        // Continuous CPU writes competing with a non-urgent display.
        lat = 1; line_words = 8'd8; cpu_mode = 1;
        pulse_line(1);
        disp_log.delete();
        for (int i = 0; i < 150; i++) begin
            pix_rd = (i % 4 == 0);
            tick();
        end
        pix_rd = 0; cpu_mode = 0;
        check("cpu_vs_disp_reads", 32'(disp_log.size()), 32'd8);
        repeat (10) tick();

        // Underflow is sticky until reset.
        video_on_v = 0;
        rst = 1; tick(); rst = 0;
        pix_rd = 1; tick(); pix_rd = 0;
        check("underflow_set", 32'(underflow), 32'd1);
        repeat (5) tick();
        check("underflow_hold", 32'(underflow), 32'd1);
        rst = 1; tick(); rst = 0;
        check("underflow_clr", 32'(underflow), 32'd0);

        // Randomized traffic.
        cpu_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            enable_crtc = ($urandom_range(0, 7) != 0);
            line_start  = ($urandom_range(0, 29) == 0);
            frame_start = line_start && ($urandom_range(0, 3) == 0);
            if (frame_start) begin
                start_addr = AW'($urandom);
                pitch      = 8'($urandom);
                line_words = 8'($urandom_range(0, 8));
            end
            pix_rd = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) video_on_v = ~video_on_v;
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 3);
            if ($urandom_range(0, 299) == 0) cpu_mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 699) == 0);
            tick();
        end
        rst = 0; line_start = 0; frame_start = 0; pix_rd = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
